// File: rtl/array_9_access_ctrl.sv
// array_9_access_ctrl: ready/valid front end for the 512x13 1R1W table SRAM (array_9_ext).
// Optional macro SRAM_INIT_EN: zero-fill sweep of every SRAM entry after reset release.
module array_9_access_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 13,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done,
  output logic              sram_R0_en,
  output logic [ADDR_W-1:0] sram_R0_addr,
  input  logic [DATA_W-1:0] sram_R0_data,
  output logic              sram_W0_en,
  output logic [ADDR_W-1:0] sram_W0_addr,
  output logic [DATA_W-1:0] sram_W0_data
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  logic              init_done_q, init_done_d;
  logic              s1_v_q, s1_v_d;
  logic              s1_fwd_q, s1_fwd_d;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
  logic [DATA_W-1:0] fifo_mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    occ;
  logic              rd_fire, wr_fire, push, pop;
  logic [DATA_W-1:0] push_data;

`ifdef SRAM_INIT_EN
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_active;

  // Sweep counter: one zero write per cycle until the last entry is written.
  always_comb begin
    init_active = !init_done_q && !reset;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (init_active) begin
      init_cnt_d  = init_cnt_q + ADDR_W'(1);
      init_done_d = (init_cnt_q == {ADDR_W{1'b1}});
    end else begin
      init_cnt_d  = init_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end
`else
  always_comb begin
    init_done_d = 1'b1;
  end
`endif

  // Handshakes and SRAM port drive; ready depends on registered state only.
  always_comb begin
    occ          = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(s1_v_q);
    rd_req_ready = init_done_q && (occ < (CNT_W+1)'(RESP_DEPTH));
    wr_ready     = init_done_q;
    init_done    = init_done_q;
    rd_fire      = rd_req_valid && rd_req_ready;
    wr_fire      = wr_valid && wr_ready;
    sram_R0_en   = rd_fire;
    sram_R0_addr = rd_req_addr;
`ifdef SRAM_INIT_EN
    if (init_active) begin
      sram_W0_en   = 1'b1;
      sram_W0_addr = init_cnt_q;
      sram_W0_data = '0;
    end else begin
      sram_W0_en   = wr_fire;
      sram_W0_addr = wr_addr;
      sram_W0_data = wr_data;
    end
`else
    sram_W0_en   = wr_fire;
    sram_W0_addr = wr_addr;
    sram_W0_data = wr_data;
`endif
  end

  // S1 holds the in-flight read; a same-address write in the accept cycle wins over SRAM data.
  always_comb begin
    s1_v_d     = rd_fire;
    s1_fwd_d   = wr_fire && (wr_addr == rd_req_addr);
    s1_wdata_d = wr_data;
    push       = s1_v_q;
    push_data  = s1_fwd_q ? s1_wdata_q : sram_R0_data;
  end

  // Response FIFO pointers and occupancy.
  always_comb begin
    rd_resp_valid = (cnt_q != '0);
    rd_resp_data  = fifo_mem_q[rptr_q];
    pop           = rd_resp_valid && rd_resp_ready;
    wptr_d        = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d        = pop ? ptr_inc(rptr_q) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset drops any in-flight read and all queued responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_done_q <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_fwd_q    <= 1'b0;
      s1_wdata_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      init_done_q <= init_done_d;
      s1_v_q      <= s1_v_d;
      s1_fwd_q    <= s1_fwd_d;
      s1_wdata_q  <= s1_wdata_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_array_9_access_ctrl.sv
// Self-checking bench for array_9_access_ctrl: behavioural SRAM, table-driven vectors and a response scoreboard.
module tb_array_9_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [8:0]  rd_req_addr = 9'h000;
  logic        rd_resp_valid, rd_resp_ready = 1'b1;
  logic [12:0] rd_resp_data;
  logic        wr_valid = 1'b0, wr_ready;
  logic [8:0]  wr_addr = 9'h000;
  logic [12:0] wr_data = 13'h0000;
  logic        init_done;
  logic        sram_R0_en, sram_W0_en;
  logic [8:0]  sram_R0_addr, sram_W0_addr;
  logic [12:0] sram_R0_data, sram_W0_data;

`ifdef SRAM_INIT_EN
  localparam int EXP_INIT = 512;
`else
  localparam int EXP_INIT = 1;
`endif

  array_9_access_ctrl dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done),
    .sram_R0_en(sram_R0_en), .sram_R0_addr(sram_R0_addr), .sram_R0_data(sram_R0_data),
    .sram_W0_en(sram_W0_en), .sram_W0_addr(sram_W0_addr), .sram_W0_data(sram_W0_data)
  );

  always #5 clock = ~clock;

  // Behavioural 1R1W SRAM: read data one cycle after R0_en, read-before-write on collision.
  logic [12:0] sram_mem [512];
  always @(posedge clock) begin
    if (sram_R0_en) sram_R0_data <= sram_mem[sram_R0_addr];
    if (sram_W0_en) sram_mem[sram_W0_addr] <= sram_W0_data;
  end

  typedef struct {
    logic        wv;
    logic [8:0]  wa;
    logic [12:0] wd;
    logic        rv;
    logic [8:0]  ra;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    logic [12:0] data;
    int          cyc;
  } sb_t;

  vec_t        tbl [24];
  logic [12:0] vals [8];
  sb_t         sb [$];
  int          checks = 0, errors = 0, pops = 0, cyc_cnt = 0;
  bit          lat_chk = 1'b1;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pop must match the oldest expected entry.
  always @(negedge clock) begin : mon
    sb_t e;
    if (rd_resp_valid === 1'b1 && rd_resp_ready) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got data 0x%0h expected no response", rd_resp_data);
      end else begin
        e = sb.pop_front();
        chk("resp_data", rd_resp_data, e.data);
        if (lat_chk) chk("resp_latency", cyc_cnt - e.cyc, 2);
      end
    end
  end

  // One bus cycle: drive after the edge, check at mid-cycle, push expected data on read accept.
  task automatic cyc(input logic wv, input logic [8:0] wa, input logic [12:0] wd,
                     input logic rv, input logic [8:0] ra, input logic [12:0] exp,
                     input logic rr, input logic chk_rdy, input logic exp_rdy, output logic acc);
    sb_t e;
    @(posedge clock);
    #1;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_req_valid = rv; rd_req_addr = ra; rd_resp_ready = rr;
    @(negedge clock);
    if (chk_rdy) begin
      chk("wr_ready", wr_ready, 1);
      chk("rd_req_ready", rd_req_ready, exp_rdy);
    end
    chk("W0_en", sram_W0_en, wv && wr_ready);
    if (wv && wr_ready) begin
      chk("W0_addr", sram_W0_addr, wa);
      chk("W0_data", sram_W0_data, wd);
    end
    acc = rv && rd_req_ready;
    chk("R0_en", sram_R0_en, acc);
    if (acc) begin
      chk("R0_addr", sram_R0_addr, ra);
      e.data = exp;
      e.cyc  = cyc_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic chk_rdy);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 13'h0000, 1'b0, 9'h000, 13'h0000, 1'b1, chk_rdy, 1'b1, acc);
  endtask

  // Assert reset for hold cycles, check reset state, release, and count cycles until init_done.
  task automatic reset_and_init(input int hold, input int max_wait, output int k);
    @(posedge clock);
    #1;
    reset = 1'b1; rd_req_valid = 1'b0; wr_valid = 1'b0; rd_resp_ready = 1'b1;
    sb.delete();
    repeat (hold) @(posedge clock);
    @(negedge clock);
    chk("rst_resp_valid", rd_resp_valid, 0);
    chk("rst_rd_req_ready", rd_req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_R0_en", sram_R0_en, 0);
    chk("rst_W0_en", sram_W0_en, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= max_wait; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (init_done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   k, acc_n, p0;
    logic acc;
    for (int i = 0; i < 512; i++) sram_mem[i] = 13'h0000;

    tbl[0]  = '{1'b1, 9'h000, 13'h0100, 1'b0, 9'h000, 13'h0000};
    tbl[1]  = '{1'b1, 9'h001, 13'h0111, 1'b0, 9'h000, 13'h0000};
    tbl[2]  = '{1'b1, 9'h002, 13'h0222, 1'b0, 9'h000, 13'h0000};
    tbl[3]  = '{1'b1, 9'h003, 13'h0333, 1'b0, 9'h000, 13'h0000};
    tbl[4]  = '{1'b1, 9'h004, 13'h0444, 1'b0, 9'h000, 13'h0000};
    tbl[5]  = '{1'b1, 9'h005, 13'h0555, 1'b0, 9'h000, 13'h0000};
    tbl[6]  = '{1'b1, 9'h006, 13'h0666, 1'b0, 9'h000, 13'h0000};
    tbl[7]  = '{1'b1, 9'h007, 13'h1777, 1'b0, 9'h000, 13'h0000};
    tbl[8]  = '{1'b1, 9'h1F0, 13'h0001, 1'b0, 9'h000, 13'h0000};
    tbl[9]  = '{1'b1, 9'h010, 13'h0AAA, 1'b0, 9'h000, 13'h0000};
    tbl[10] = '{1'b1, 9'h005, 13'h1ABC, 1'b0, 9'h000, 13'h0000};
    tbl[11] = '{1'b0, 9'h000, 13'h0000, 1'b1, 9'h005, 13'h1ABC};
    tbl[12] = '{1'b1, 9'h1F0, 13'h0777, 1'b1, 9'h1F0, 13'h0777};
    tbl[13] = '{1'b0, 9'h000, 13'h0000, 1'b1, 9'h010, 13'h0AAA};
    tbl[14] = '{1'b1, 9'h010, 13'h0BBB, 1'b1, 9'h1F0, 13'h0777};
    tbl[15] = '{1'b0, 9'h000, 13'h0000, 1'b1, 9'h010, 13'h0BBB};
    vals = '{13'h0100, 13'h0111, 13'h0222, 13'h0333, 13'h0444, 13'h1ABC, 13'h0666, 13'h1777};
    for (int i = 0; i < 8; i++) tbl[16+i] = '{1'b0, 9'h000, 13'h0000, 1'b1, 9'(i), vals[i]};

    reset_and_init(3, 1000, k);
    chk("init_latency", k, EXP_INIT);

    // Table: writes, forwarding, write-after-read ordering, back-to-back streaming.
    lat_chk = 1'b1;
    for (int i = 0; i < 24; i++)
      cyc(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].exp, 1'b1, 1'b1, 1'b1, acc);
    idle(4, 1'b1);
    chk("table_drained", sb.size(), 0);

    // Backpressure: consumer stalled, only RESP_DEPTH reads may be outstanding.
    lat_chk = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 9'h000, 13'h0000, 1'b1, 9'(i), vals[i], 1'b0, 1'b0, 1'b0, acc);
      acc_n += int'(acc);
    end
    chk("bp_accepted", acc_n, 3);
    chk("bp_ready_low", rd_req_ready, 0);
    p0 = pops;
    idle(4, 1'b0);
    chk("bp_released_pops", pops - p0, 3);
    chk("bp_ready_back", rd_req_ready, 1);
    chk("bp_drained", sb.size(), 0);

    // Reset with a read in flight: no response may appear.
    lat_chk = 1'b1;
    cyc(1'b0, 9'h000, 13'h0000, 1'b1, 9'h003, 13'h0333, 1'b1, 1'b1, 1'b1, acc);
    p0 = pops;
    reset_and_init(2, 1000, k);
    chk("reinit_latency", k, EXP_INIT);
    idle(3, 1'b1);
    chk("inflight_dropped", pops - p0, 0);
    cyc(1'b0, 9'h000, 13'h0000, 1'b1, 9'h007, 13'h1777, 1'b1, 1'b1, 1'b1, acc);
    idle(4, 1'b1);
    chk("post_reset_drained", sb.size(), 0);

`ifdef SRAM_INIT_EN
    // Sweep restart on reset mid-init, then the swept entry reads back as zero.
    cyc(1'b1, 9'h1FF, 13'h1234, 1'b0, 9'h000, 13'h0000, 1'b1, 1'b1, 1'b1, acc);
    reset_and_init(2, 100, k);
    chk("init_not_early", k, 0);
    chk("init_wr_ready_low", wr_ready, 0);
    chk("init_rd_ready_low", rd_req_ready, 0);
    reset_and_init(1, 1000, k);
    chk("init_restart_latency", k, 512);
    cyc(1'b0, 9'h000, 13'h0000, 1'b1, 9'h1FF, 13'h0000, 1'b1, 1'b1, 1'b1, acc);
    idle(4, 1'b1);
    chk("init_drained", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
